// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: drives synchronous instruction-memory reads and
// buffers returned instructions with their PCs in a prefetch FIFO for decode.
// A redirect from execute retargets fetch and flushes all speculative work.
module instr_fetch_queue #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        instr_mem_addr,
  output logic                     instr_mem_rd_en,
  input  logic [INSTR_W-1:0]       instr_mem_data,
  input  logic                     redirect_en,
  input  logic [ADDR_W-1:0]        redirect_addr,
  output logic [INSTR_W-1:0]       instr_out,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  // Architectural state
  logic [ADDR_W-1:0]  fetch_pc_q,    fetch_pc_d;
  logic               inflight_q,    inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0]   count_q,       count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_d    [DEPTH];

  logic [OCC_W-1:0]   occupied;
  logic               issue;
  logic               push;
  logic               pop;

  // Credit check: buffered plus in-flight entries must leave room for one more
  // read. Same-cycle pops are deliberately not counted as credit.
  always_comb begin
    occupied = {1'b0, count_q} + OCC_W'(inflight_q);
    issue    = !reset && !redirect_en && (occupied < OCC_W'(DEPTH));
    push     = inflight_q && !redirect_en;
    pop      = (count_q != '0) && instr_ready && !redirect_en;
  end

  // Next-state for fetch PC, in-flight tracking and FIFO storage
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    instr_mem_d   = instr_mem_q;
    pc_mem_d      = pc_mem_q;

    if (redirect_en) begin
      // Flush: pending return and buffered entries all belong to the old path
      fetch_pc_d = redirect_addr;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = ADDR_W'(fetch_pc_q + 1'b1);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else begin
        inflight_d = 1'b0;
      end

      if (push) begin
        instr_mem_d[wr_ptr_q] = instr_mem_data;
        pc_mem_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d              = PTR_W'(wr_ptr_q + 1'b1);
      end

      if (pop) begin
        rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      end

      case ({push, pop})
        2'b10:   count_d = CNT_W'(count_q + 1'b1);
        2'b01:   count_d = CNT_W'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      instr_mem_q   <= instr_mem_d;
      pc_mem_q      <= pc_mem_d;
    end
  end

  // Outputs are register-derived except the read strobe
  always_comb begin
    instr_mem_addr  = fetch_pc_q;
    instr_mem_rd_en = issue;
    instr_out       = instr_mem_q[rd_ptr_q];
    instr_pc        = pc_mem_q[rd_ptr_q];
    instr_valid     = (count_q != '0);
    queue_count     = count_q;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios followed by random ready and
// redirect traffic, checked against a transaction-level fetch-stream model.
module tb_instr_fetch_queue;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DEPTH   = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [ADDR_W-1:0]  instr_mem_addr;
  logic               instr_mem_rd_en;
  logic [INSTR_W-1:0] instr_mem_data = '0;
  logic               redirect_en = 1'b0;
  logic [ADDR_W-1:0]  redirect_addr = '0;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready = 1'b1;
  logic [2:0]         queue_count;

  int     checks = 0;
  int     failures = 0;
  int     n_pops = 0;
  int     rst_events = 0;
  entry_t exp_q[$];
  logic               pend_v = 1'b0;
  logic [ADDR_W-1:0]  pend_a = '0;

  instr_fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .instr_mem_addr(instr_mem_addr), .instr_mem_rd_en(instr_mem_rd_en),
    .instr_mem_data(instr_mem_data),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return 16'(a) + 16'h0100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: data for an address sampled at an edge is valid the following cycle
  always @(posedge clk) instr_mem_data <= pend_v ? mem_f(pend_a) : 16'hDEAD;

  // Monitor: pop the scoreboard whenever decode accepts the head
  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && instr_valid && instr_ready && !redirect_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual_pc=0x%0h expected=none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("head_pc", 32'(instr_pc), 32'(e.pc));
          chk("head_instr", 32'(instr_out), 32'(e.instr));
          n_pops++;
        end
      end
    end
  end

  // Reference model: the fetch stream is a sequential PC walk, limited by
  // DEPTH slots of credit, restarted by redirect or reset
  initial begin : model
    int               m_count;
    bit               m_inflight;
    logic [ADDR_W-1:0] m_pc;
    int               seen_rst;
    bit               issue;
    bit               pop;
    m_count = 0; m_inflight = 0; m_pc = '0; seen_rst = 0;
    forever begin
      @(negedge clk);
      #3;
      pend_v = instr_mem_rd_en;
      pend_a = instr_mem_addr;
      if (reset || seen_rst != rst_events) begin
        seen_rst   = rst_events;
        m_count    = 0;
        m_inflight = 0;
        m_pc       = '0;
        exp_q.delete();
      end
      if (reset) begin
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_count", 32'(queue_count), 0);
        chk("rst_rd_en", 32'(instr_mem_rd_en), 0);
        chk("rst_addr", 32'(instr_mem_addr), 0);
        chk("rst_instr_out", 32'(instr_out), 0);
        chk("rst_instr_pc", 32'(instr_pc), 0);
      end else begin
        issue = !redirect_en && (m_count + int'(m_inflight) < int'(DEPTH));
        chk("count", 32'(queue_count), 32'(m_count));
        chk("valid", 32'(instr_valid), 32'(m_count > 0));
        chk("rd_en", 32'(instr_mem_rd_en), 32'(issue));
        chk("addr", 32'(instr_mem_addr), 32'(m_pc));
        if (redirect_en) begin
          m_pc       = redirect_addr;
          m_count    = 0;
          m_inflight = 0;
          exp_q.delete();
        end else begin
          pop        = (m_count > 0) && instr_ready;
          m_count    = m_count + int'(m_inflight) - int'(pop);
          m_inflight = issue;
          if (issue) begin
            exp_q.push_back({mem_f(m_pc), m_pc});
            m_pc = 13'(m_pc + 1);
          end
        end
      end
    end
  end

  // Set inputs for the next edge
  task automatic cycle(input bit rdy, input bit redir, input logic [ADDR_W-1:0] tgt);
    @(negedge clk);
    instr_ready   = rdy;
    redirect_en   = redir;
    redirect_addr = tgt;
  endtask

  // Half-cycle asynchronous reset pulse just after a rising edge
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    rst_events++;
    #1;
    chk("prst_valid", 32'(instr_valid), 0);
    chk("prst_count", 32'(queue_count), 0);
    chk("prst_addr", 32'(instr_mem_addr), 0);
    chk("prst_rd_en", 32'(instr_mem_rd_en), 0);
    chk("prst_instr_out", 32'(instr_out), 0);
    chk("prst_instr_pc", 32'(instr_pc), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Cycle-bounded wait until the FIFO holds n entries with decode stalled
  task automatic fill_to(input int n);
    int k;
    k = 0;
    while (int'(queue_count) != n && k < 20) begin
      cycle(0, 0, '0);
      k++;
    end
    chk("fill_wait", 32'(queue_count), 32'(n));
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int p0;
    // Boot: first instruction valid after two edges, then one per cycle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cycle(1, 0, '0); #3;
    chk("boot_valid_e0", 32'(instr_valid), 0);
    cycle(1, 0, '0); #3;
    chk("boot_valid_e1", 32'(instr_valid), 1);
    chk("boot_pc", 32'(instr_pc), 0);
    chk("boot_instr", 32'(instr_out), 32'h0100);
    p0 = n_pops;
    repeat (8) cycle(1, 0, '0);
    #3;
    chk("throughput", 32'(n_pops - p0), 8);

    // Stall from a fresh start: FIFO fills to DEPTH, fetch stops
    pulse_reset();
    repeat (10) cycle(0, 0, '0);
    #3;
    chk("stall_count", 32'(queue_count), 4);
    chk("stall_rd_en", 32'(instr_mem_rd_en), 0);
    chk("stall_addr", 32'(instr_mem_addr), 4);
    chk("stall_head", 32'(instr_pc), 0);
    repeat (8) cycle(1, 0, '0);

    // Redirect with three buffered entries and a read in flight
    fill_to(3);
    instr_ready = 1'b1; redirect_en = 1'b1; redirect_addr = 13'h0A00;
    cycle(1, 0, '0); #3;
    chk("redir_flush", 32'(queue_count), 0);
    chk("redir_addr", 32'(instr_mem_addr), 32'h0A00);
    cycle(1, 0, '0); #3;
    chk("redir_bubble", 32'(instr_valid), 0);
    cycle(1, 0, '0); #3;
    chk("redir_valid", 32'(instr_valid), 1);
    chk("redir_pc", 32'(instr_pc), 32'h0A00);
    repeat (4) cycle(1, 0, '0);

    // Address wrap
    cycle(1, 1, 13'h1FFE);
    repeat (10) cycle(1, 0, '0);

    // Redirect coincident with push and pop, then a second one
    cycle(1, 1, 13'h0123);
    cycle(1, 1, 13'h0040); #3;
    chk("rr_count1", 32'(queue_count), 0);
    cycle(1, 0, '0); #3;
    chk("rr_count2", 32'(queue_count), 0);
    chk("rr_addr", 32'(instr_mem_addr), 32'h0040);
    repeat (8) cycle(1, 0, '0);

    // Mid-stream reset with three entries buffered
    fill_to(3);
    pulse_reset();
    cycle(1, 0, '0); #3;
    chk("rst2_valid_e0", 32'(instr_valid), 0);
    cycle(1, 0, '0); #3;
    chk("rst2_valid_e1", 32'(instr_valid), 1);
    chk("rst2_pc", 32'(instr_pc), 0);
    repeat (6) cycle(1, 0, '0);

    // Random ready and redirect traffic
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            ($urandom_range(0, 3) == 0) ? 13'h1FFE : 13'($urandom));
    end
    repeat (12) cycle(1, 0, '0);
    #3;
    chk("pops_seen", 32'(n_pops > 200), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
